rx_sync_ctrl: RTL
=================

Name: rx_sync_ctrl

Overview:
- Byte-level receive-link synchronization controller. Sits after the serial-to-parallel converter in the demux receive path.
- Sequences link bring-up: comma (BC) lock, then IDLE (7C) detection, then data forwarding.
- Tracks coding errors and drops back to loss-of-sync when errors accumulate.
- Runs in the byte clock domain and gates which parallel bytes reach the downstream demux.

Parameters:
BC_WORD, 8'hBC, comma/alignment control word
IDLE_WORD, 8'h7C, idle control word
BC_LOCK, 4, consecutive BC words required to declare sync (1..7)
ERR_LIMIT, 3, consecutive errored bytes that force loss of sync (1..3)

Ports:
clk_4f  input  1  byte clock; all logic on posedge
reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, 1 = run
data_in  input  8  parallel byte from serial-to-parallel converter
valid_in  input  1  data_in holds a new byte this cycle
err_in  input  1  coding error on current byte; qualified by valid_in
data_out  output  8  forwarded data byte
valid_out  output  1  data_out valid (data bytes only, never control words)
idle_out  output  1  link in IDLE state
active  output  1  link synchronized (SYNC, IDLE or ACTIVE state)
state  output  3  current state encoding
bc_count  output  3  consecutive BC count
err_count  output  2  consecutive error count

Behaviour:
- Reset (reset=0, async): state=LOSS, bc_count=0, err_count=0, data_out=8'h00, valid_out=0, idle_out=0, active=0.
- All outputs are registered. A byte presented at edge N is reflected on the outputs after edge N, which is one cycle of latency.
- valid_in=0: state and counters hold. valid_out=0 that cycle. data_out holds its last value.
- State encoding: LOSS=0, ALIGN=1, SYNC=2, IDLE=3, ACTIVE=4. Other codes go to LOSS on the next edge.
- LOSS:
  - A valid BC byte sets bc_count=1 and moves to ALIGN.
  - Any other valid byte leaves bc_count at 0.
  - err_in is ignored.
- ALIGN:
  - A valid BC byte increments bc_count.
  - When the incremented value equals BC_LOCK, go to SYNC. bc_count saturates at BC_LOCK.
  - A valid non-BC byte, or err_in=1, clears bc_count and returns to LOSS.
- SYNC (active=1):
  - A BC byte stays in SYNC.
  - An IDLE_WORD byte goes to IDLE (idle_out=1 from the next cycle).
  - Any other byte is an error.
- IDLE (active=1, idle_out=1):
  - BC or IDLE bytes stay in IDLE.
  - Any other error-free valid byte goes to ACTIVE and is forwarded that same edge (valid_out=1, data_out=byte).
- ACTIVE (active=1, idle_out=0):
  - Non-control error-free bytes are forwarded.
  - An IDLE_WORD byte returns to IDLE and is not forwarded.
  - A BC byte is absorbed (not forwarded) and the state holds.
- Error accounting in SYNC/IDLE/ACTIVE:
  - An error is a valid byte with err_in=1, or an unexpected word in SYNC.
  - Each error increments err_count. The errored byte is never forwarded and the state is otherwise unchanged.
  - When err_count reaches ERR_LIMIT, go to LOSS with bc_count=0, err_count=0, active=0, idle_out=0, valid_out=0.
  - Any error-free valid byte clears err_count to 0.
- Control words are never forwarded (valid_out=0 for BC/IDLE).
- Mid-operation reset: immediate return to reset values. No bytes are forwarded while reset=0.

Test Plan:
- Reset low, then release, then BC x4 (valid) -> state 0->1->1->1->2 on consecutive edges; active=1 one cycle after the 4th BC; bc_count=4.
- BC x3, then 8'h55, then BC x4 -> back to LOSS on 8'h55 with bc_count=0; SYNC reached only after the second full run of 4.
- Lock, then 7C, then 8'hA1, 8'hA2, then 7C -> idle_out=1 after 7C; valid_out=1 with data_out=A1 then A2; then idle_out=1 and valid_out=0 after the final 7C.
- ACTIVE, err_in=1 on 2 bytes, then a good byte 8'h33, then err_in=1 on 3 bytes -> err_count 1,2,0 (33 forwarded), then 1,2, then LOSS on the 3rd error with active=0.
- ACTIVE with valid_in toggling 1,0,1 and bytes 8'h10, 8'h20 -> valid_out pulses only for the valid cycles; state holds through the gap.
- Reset asserted asynchronously mid-ACTIVE (between edges) -> all outputs go to their reset values immediately without a clock edge.

Source files
------------

// File: rtl/rx_sync_ctrl.sv
// Byte-clock receive synchronization controller: comma lock, idle detection,
// data forwarding and error-driven loss of sync for the demux receive path.
module rx_sync_ctrl #(
   parameter logic [7:0]  BC_WORD   = 8'hBC,
   parameter logic [7:0]  IDLE_WORD = 8'h7C,
   parameter int unsigned BC_LOCK   = 4,
   parameter int unsigned ERR_LIMIT = 3
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   input  logic       err_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       idle_out,
   output logic       active,
   output logic [2:0] state,
   output logic [2:0] bc_count,
   output logic [1:0] err_count
);

   typedef enum logic [2:0] {
      ST_LOSS   = 3'd0,
      ST_ALIGN  = 3'd1,
      ST_SYNC   = 3'd2,
      ST_IDLE   = 3'd3,
      ST_ACTIVE = 3'd4
   } state_t;

   localparam logic [2:0] BC_LOCK_C   = 3'(BC_LOCK);
   localparam logic [2:0] ERR_LIMIT_C = 3'(ERR_LIMIT);

   state_t     state_r, state_s;
   logic [2:0] bc_r, bc_s;
   logic [1:0] err_r, err_s;
   logic [7:0] data_r, data_s;
   logic       valid_r, idle_r, active_r;
   logic       fwd_s, err_hit_s, is_bc_s, is_idle_s;
   logic [2:0] err_inc_s;

   function automatic logic linked(input state_t s);
      case (s)
         ST_SYNC, ST_IDLE, ST_ACTIVE: linked = 1'b1;
         default:                     linked = 1'b0;
      endcase
   endfunction

   // Next-state, counter and forwarding decisions for the current byte
   always_comb begin
      state_s   = state_r;
      bc_s      = bc_r;
      err_s     = err_r;
      data_s    = data_r;
      fwd_s     = 1'b0;
      err_hit_s = 1'b0;
      is_bc_s   = (data_in == BC_WORD);
      is_idle_s = (data_in == IDLE_WORD);
      err_inc_s = {1'b0, err_r} + 3'd1;
      if (valid_in) begin
         case (state_r)
            ST_LOSS: begin
               err_s = 2'd0;
               if (is_bc_s) begin
                  bc_s    = 3'd1;
                  state_s = (BC_LOCK_C == 3'd1) ? ST_SYNC : ST_ALIGN;
               end else begin
                  bc_s    = 3'd0;
               end
            end
            ST_ALIGN: begin
               if (err_in || !is_bc_s) begin
                  bc_s    = 3'd0;
                  state_s = ST_LOSS;
               end else if ((bc_r + 3'd1) >= BC_LOCK_C) begin
                  bc_s    = BC_LOCK_C;
                  state_s = ST_SYNC;
               end else begin
                  bc_s    = bc_r + 3'd1;
               end
            end
            ST_SYNC: begin
               if (err_in || !(is_bc_s || is_idle_s)) begin
                  err_hit_s = 1'b1;
               end else begin
                  err_s   = 2'd0;
                  state_s = is_idle_s ? ST_IDLE : ST_SYNC;
               end
            end
            ST_IDLE: begin
               if (err_in) begin
                  err_hit_s = 1'b1;
               end else begin
                  err_s = 2'd0;
                  if (is_bc_s || is_idle_s) begin
                     state_s = ST_IDLE;
                  end else begin
                     state_s = ST_ACTIVE;
                     fwd_s   = 1'b1;
                     data_s  = data_in;
                  end
               end
            end
            ST_ACTIVE: begin
               if (err_in) begin
                  err_hit_s = 1'b1;
               end else begin
                  err_s = 2'd0;
                  if (is_idle_s) begin
                     state_s = ST_IDLE;
                  end else if (is_bc_s) begin
                     state_s = ST_ACTIVE;
                  end else begin
                     fwd_s  = 1'b1;
                     data_s = data_in;
                  end
               end
            end
            default: begin
               state_s = ST_LOSS;
               bc_s    = 3'd0;
               err_s   = 2'd0;
            end
         endcase
         // Errored bytes only advance the error counter until the limit drops sync
         if (err_hit_s) begin
            if (err_inc_s >= ERR_LIMIT_C) begin
               state_s = ST_LOSS;
               bc_s    = 3'd0;
               err_s   = 2'd0;
            end else begin
               err_s   = err_inc_s[1:0];
            end
         end else begin
            err_s = err_s;
         end
      end else begin
         case (state_r)
            ST_LOSS, ST_ALIGN, ST_SYNC, ST_IDLE, ST_ACTIVE: state_s = state_r;
            default: begin
               state_s = ST_LOSS;
               bc_s    = 3'd0;
               err_s   = 2'd0;
            end
         endcase
      end
   end

   // State, counters and all registered outputs
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_LOSS;
         bc_r     <= 3'd0;
         err_r    <= 2'd0;
         data_r   <= 8'h00;
         valid_r  <= 1'b0;
         idle_r   <= 1'b0;
         active_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         bc_r     <= bc_s;
         err_r    <= err_s;
         data_r   <= data_s;
         valid_r  <= fwd_s;
         idle_r   <= (state_s == ST_IDLE);
         active_r <= linked(state_s);
      end
   end

   assign data_out  = data_r;
   assign valid_out = valid_r;
   assign idle_out  = idle_r;
   assign active    = active_r;
   assign state     = state_r;
   assign bc_count  = bc_r;
   assign err_count = err_r;

endmodule
